enthdr_tgt_detector: RTL and testbench

//  Target-side SDR front end that watches SCL/SDA for the ENTHDRx broadcast CCC sent by the controller.

---
 rtl/i3c_tgt_pkg.sv | 38 +++
 rtl/i3c_bus_cond_det.sv | 63 ++++++
 rtl/enthdr_tgt_detector.sv | 223 ++++++++++++++++++++++
 tb/tb_enthdr_tgt_detector.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i3c_tgt_pkg.sv
// ---------------------------------------------------------------------------
// i3c_tgt_pkg
// Shared definitions for the I3C target SDR front end that detects ENTHDRx:
//   - tgt_state_t        : detector FSM states
//   - I3C_BCAST_ADDR     : 7-bit I3C broadcast address
//   - I3C_ENTHDR0        : ENTHDR0 CCC code; ENTHDRx = ENTHDR0 | x
//   - I3C_SUPPORTED_MASK : bit x set -> HDR mode x supported (DDR only)
//   - enthdr_code()      : builds the ENTHDRx code for mode x
//   - odd_parity_bit()   : T-bit value that makes {byte,T} odd parity
// No ports (package).
// ---------------------------------------------------------------------------
package i3c_tgt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_WAIT,
    ST_ACK,
    ST_CCC,
    ST_HDR,
    ST_HDR_IGN
  } tgt_state_t;

  localparam logic [6:0] I3C_BCAST_ADDR     = 7'h7E;
  localparam logic [7:0] I3C_ENTHDR0        = 8'h20;
  localparam logic [7:0] I3C_SUPPORTED_MASK = 8'h01;

  function automatic logic [7:0] enthdr_code(input logic [2:0] mode);
    return I3C_ENTHDR0 | {5'b00000, mode};
  endfunction

  // The T-bit after a CCC byte gives the 9-bit word odd parity,
  // so T is 1 exactly when the byte has an even number of ones.
  function automatic logic odd_parity_bit(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/i3c_bus_cond_det.sv
// ---------------------------------------------------------------------------
// i3c_bus_cond_det
// Synchronises the asynchronous SCL/SDA bus lines into the system clock
// domain and derives single-cycle bus condition pulses from the last two
// synchronised samples.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous reset, active-high
//   scl      in  raw bus SCL (asynchronous)
//   sda      in  raw bus SDA (asynchronous)
//   sda_s    out synchronised SDA (latest sample)
//   scl_rise out 1-cycle pulse: synchronised SCL 0->1
//   scl_fall out 1-cycle pulse: synchronised SCL 1->0
//   start    out 1-cycle pulse: SDA 1->0 while SCL high (START / Sr)
//   stop     out 1-cycle pulse: SDA 0->1 while SCL high (STOP)
// ---------------------------------------------------------------------------
module i3c_bus_cond_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl_s;

  // Reset to the idle bus level (both lines high) so that leaving reset
  // never manufactures a fake edge or bus condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_q    <= scl_sync[SYNC_STAGES-1];
      sda_q    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;

  // SCL must be high in both samples so a data change during a clock
  // edge is never mistaken for a START or STOP.
  assign start = scl_s & scl_q & sda_q & ~sda_s;
  assign stop  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/enthdr_tgt_detector.sv
// ---------------------------------------------------------------------------
// enthdr_tgt_detector
// Target-side SDR front end that watches the bus for the ENTHDRx broadcast
// CCC. It matches 7'h7E+W after START, ACKs it, checks the 9-bit CCC code
// (byte + T-bit) and on a valid ENTHDRx hands the bus to the HDR engine (or
// ignores the bus for unsupported modes) until the engine reports exit.
// Ports:
//   i_sdr_clk    in   system clock, at least 4x SCL
//   i_sdr_rst    in   synchronous reset, active-high
//   i_tgt_en     in   detector enable; low returns to IDLE synchronously
//   i_scl        in   bus SCL (asynchronous)
//   i_sda        in   bus SDA (asynchronous, pulled up)
//   i_hdr_exit   in   1-cycle pulse: HDR engine done / exit pattern seen
//   o_sda_oe     out  1 = pull SDA low (ACK)
//   o_sda_pp_od  out  0 = open-drain; this block only ever drives open-drain
//   o_hdr_en     out  level: HDR engine enable (supported mode entered)
//   o_hdr_mode   out  HDR mode index x, valid with o_hdr_en/o_hdr_ignore
//   o_hdr_ignore out  level: unsupported ENTHDRx, bus ignored until exit
//   o_ccc_err    out  1-cycle pulse: T-bit parity error on the CCC code
//   o_busy       out  detector not in IDLE
// ---------------------------------------------------------------------------
module enthdr_tgt_detector
  import i3c_tgt_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic [6:0]  BCAST_ADDR     = I3C_BCAST_ADDR,
  parameter logic [7:0]  ENTHDR_BASE    = I3C_ENTHDR0,
  parameter logic [7:0]  SUPPORTED_MASK = I3C_SUPPORTED_MASK
) (
  input  logic       i_sdr_clk,
  input  logic       i_sdr_rst,
  input  logic       i_tgt_en,
  input  logic       i_scl,
  input  logic       i_sda,
  input  logic       i_hdr_exit,
  output logic       o_sda_oe,
  output logic       o_sda_pp_od,
  output logic       o_hdr_en,
  output logic [2:0] o_hdr_mode,
  output logic       o_hdr_ignore,
  output logic       o_ccc_err,
  output logic       o_busy
);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start;
  logic stop;

  i3c_bus_cond_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_cond (
    .clk      (i_sdr_clk),
    .rst      (i_sdr_rst),
    .scl      (i_scl),
    .sda      (i_sda),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  tgt_state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [8:0] shreg, shreg_nxt;
  logic       sda_oe_q, sda_oe_nxt;
  logic       hdr_en_q, hdr_en_nxt;
  logic       hdr_ign_q, hdr_ign_nxt;
  logic [2:0] hdr_mode_q, hdr_mode_nxt;
  logic       ccc_err_q, ccc_err_nxt;

  logic [7:0] addr_byte;
  logic [7:0] ccc_byte;
  logic       ccc_tbit;
  logic [2:0] ccc_mode;

  // The address byte is judged on the same cycle its 8th bit arrives,
  // so the incoming bit is appended to the seven already shifted in.
  assign addr_byte = {shreg[6:0], sda_s};
  assign ccc_byte  = shreg[8:1];
  assign ccc_tbit  = shreg[0];
  assign ccc_mode  = shreg[3:1];

  // Next-state and next-output logic. START/STOP take priority over SCL
  // edges in every SDR frame state; once in HDR the engine owns the bus
  // and only i_hdr_exit is honoured.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    shreg_nxt    = shreg;
    sda_oe_nxt   = sda_oe_q;
    hdr_en_nxt   = hdr_en_q;
    hdr_ign_nxt  = hdr_ign_q;
    hdr_mode_nxt = hdr_mode_q;
    ccc_err_nxt  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_ADDR;
          cnt_nxt   = '0;
          shreg_nxt = '0;
        end
      end

      ST_HDR, ST_HDR_IGN: begin
        if (i_hdr_exit) begin
          state_nxt    = ST_IDLE;
          hdr_en_nxt   = 1'b0;
          hdr_ign_nxt  = 1'b0;
          hdr_mode_nxt = '0;
        end
      end

      default: begin
        if (start) begin
          state_nxt  = ST_ADDR;
          cnt_nxt    = '0;
          shreg_nxt  = '0;
          sda_oe_nxt = 1'b0;
        end else if (stop) begin
          state_nxt  = ST_IDLE;
          cnt_nxt    = '0;
          shreg_nxt  = '0;
          sda_oe_nxt = 1'b0;
        end else begin
          case (state)
            ST_ADDR: begin
              if (scl_rise) begin
                shreg_nxt = {shreg[7:0], sda_s};
                cnt_nxt   = cnt + 4'd1;
                if (cnt == 4'd7) begin
                  cnt_nxt   = '0;
                  state_nxt = (addr_byte == {BCAST_ADDR, 1'b0}) ? ST_ACK_WAIT : ST_IDLE;
                end
              end
            end

            ST_ACK_WAIT: begin
              if (scl_fall) begin
                sda_oe_nxt = 1'b1;
                state_nxt  = ST_ACK;
              end
            end

            // The first fall seen in ACK always ends the 9th (ACK) bit,
            // since ACK is entered on the fall that ends the 8th bit.
            ST_ACK: begin
              if (scl_fall) begin
                sda_oe_nxt = 1'b0;
                state_nxt  = ST_CCC;
                cnt_nxt    = '0;
                shreg_nxt  = '0;
              end
            end

            // cnt reaching 9 means byte + T-bit are complete; they are
            // evaluated one cycle after the last bit is shifted in.
            ST_CCC: begin
              if (cnt == 4'd9) begin
                cnt_nxt = '0;
                if (ccc_tbit != odd_parity_bit(ccc_byte)) begin
                  ccc_err_nxt = 1'b1;
                  state_nxt   = ST_IDLE;
                end else if (ccc_byte[7:3] != ENTHDR_BASE[7:3]) begin
                  state_nxt = ST_IDLE;
                end else if (SUPPORTED_MASK[ccc_mode]) begin
                  state_nxt    = ST_HDR;
                  hdr_en_nxt   = 1'b1;
                  hdr_mode_nxt = ccc_mode;
                end else begin
                  state_nxt    = ST_HDR_IGN;
                  hdr_ign_nxt  = 1'b1;
                  hdr_mode_nxt = ccc_mode;
                end
              end else if (scl_rise) begin
                shreg_nxt = {shreg[7:0], sda_s};
                cnt_nxt   = cnt + 4'd1;
              end
            end

            default: ;
          endcase
        end
      end
    endcase
  end

  // State and output registers. Disabling the detector behaves like reset
  // so an ACK in progress is released on the very same edge.
  always_ff @(posedge i_sdr_clk) begin
    if (i_sdr_rst || !i_tgt_en) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      sda_oe_q   <= 1'b0;
      hdr_en_q   <= 1'b0;
      hdr_ign_q  <= 1'b0;
      hdr_mode_q <= '0;
      ccc_err_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shreg      <= shreg_nxt;
      sda_oe_q   <= sda_oe_nxt;
      hdr_en_q   <= hdr_en_nxt;
      hdr_ign_q  <= hdr_ign_nxt;
      hdr_mode_q <= hdr_mode_nxt;
      ccc_err_q  <= ccc_err_nxt;
    end
  end

  assign o_sda_oe     = sda_oe_q;
  assign o_sda_pp_od  = 1'b0;
  assign o_hdr_en     = hdr_en_q;
  assign o_hdr_mode   = hdr_mode_q;
  assign o_hdr_ignore = hdr_ign_q;
  assign o_ccc_err    = ccc_err_q;
  assign o_busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_enthdr_tgt_detector.sv
// ---------------------------------------------------------------------------
// tb_enthdr_tgt_detector
// Directed bench for enthdr_tgt_detector. A bus controller model drives
// SCL/SDA (SDA wired-AND with the target's open-drain pull-down) at a slow
// SCL rate, 16 system clocks per bit. Expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_enthdr_tgt_detector;
  import i3c_tgt_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       tgt_en;
  logic       ctrl_scl;
  logic       ctrl_sda;
  logic       hdr_exit;
  logic       bus_sda;
  logic       sda_oe;
  logic       sda_pp_od;
  logic       hdr_en;
  logic [2:0] hdr_mode;
  logic       hdr_ignore;
  logic       ccc_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int err_cycles = 0;
  int oe_cycles  = 0;

  always #5 clk = ~clk;

  // Open-drain bus: the line is low if either side pulls it low.
  assign bus_sda = ctrl_sda & ~sda_oe;

  enthdr_tgt_detector dut (
    .i_sdr_clk    (clk),
    .i_sdr_rst    (rst),
    .i_tgt_en     (tgt_en),
    .i_scl        (ctrl_scl),
    .i_sda        (bus_sda),
    .i_hdr_exit   (hdr_exit),
    .o_sda_oe     (sda_oe),
    .o_sda_pp_od  (sda_pp_od),
    .o_hdr_en     (hdr_en),
    .o_hdr_mode   (hdr_mode),
    .o_hdr_ignore (hdr_ignore),
    .o_ccc_err    (ccc_err),
    .o_busy       (busy)
  );

  // Cycle counters used to measure pulse widths and ACK activity.
  always @(negedge clk) begin
    if (ccc_err === 1'b1) err_cycles++;
    if (sda_oe === 1'b1) oe_cycles++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    ctrl_sda = 1'b1; clks(4);
    ctrl_scl = 1'b1; clks(8);
    ctrl_sda = 1'b0; clks(8);
    ctrl_scl = 1'b0; clks(4);
  endtask

  task automatic bus_stop();
    ctrl_sda = 1'b0; clks(4);
    ctrl_scl = 1'b1; clks(8);
    ctrl_sda = 1'b1; clks(8);
  endtask

  task automatic bus_bit(input logic b);
    ctrl_sda = b;    clks(4);
    ctrl_scl = 1'b1; clks(8);
    ctrl_scl = 1'b0; clks(4);
  endtask

  task automatic bus_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bus_bit(b[i]);
  endtask

  task automatic ack_slot(output logic oe_mid);
    ctrl_sda = 1'b1; clks(4);
    ctrl_scl = 1'b1; clks(4);
    oe_mid = sda_oe; clks(4);
    ctrl_scl = 1'b0; clks(4);
  endtask

  // Final (T) bit with hdr_en sampled 3 and 4 system clocks after SCL rises.
  task automatic last_bit(input logic b, output logic en3, output logic en4);
    ctrl_sda = b;    clks(4);
    ctrl_scl = 1'b1; clks(3);
    en3 = hdr_en;    clks(1);
    en4 = hdr_en;    clks(4);
    ctrl_scl = 1'b0; clks(4);
  endtask

  task automatic pulse_exit();
    hdr_exit = 1'b1; clks(1);
    hdr_exit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tgt_en = 1'b1; hdr_exit = 1'b0;
    ctrl_scl = 1'b1; ctrl_sda = 1'b1;
    clks(4);
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("[TB] FAIL reset_oe: got %b expected 0", sda_oe); end
    checks++; if (sda_pp_od !== 1'b0) begin failures++; $display("[TB] FAIL reset_pp_od: got %b expected 0", sda_pp_od); end
    checks++; if (hdr_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_hdr_en: got %b expected 0", hdr_en); end
    checks++; if (hdr_mode !== 3'd0) begin failures++; $display("[TB] FAIL reset_mode: got %0d expected 0", hdr_mode); end
    checks++; if (hdr_ignore !== 1'b0) begin failures++; $display("[TB] FAIL reset_ignore: got %b expected 0", hdr_ignore); end
    checks++; if (ccc_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", ccc_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    clks(4);
  endtask

  task automatic test_enthdr0_entry();
    logic m, e3, e4;
    bus_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL entry_busy_after_start: got %b expected 1", busy); end
    bus_byte({I3C_BCAST_ADDR, 1'b0});
    ack_slot(m);
    checks++; if (m !== 1'b1) begin failures++; $display("[TB] FAIL entry_ack_driven: got %b expected 1", m); end
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("[TB] FAIL entry_ack_released: got %b expected 0", sda_oe); end
    bus_byte(8'h20);
    last_bit(1'b0, e3, e4);
    checks++; if (e3 !== 1'b0) begin failures++; $display("[TB] FAIL entry_latency_early: got %b expected 0", e3); end
    checks++; if (e4 !== 1'b1) begin failures++; $display("[TB] FAIL entry_latency_on_time: got %b expected 1", e4); end
    checks++; if (hdr_mode !== 3'd0) begin failures++; $display("[TB] FAIL entry_mode: got %0d expected 0", hdr_mode); end
    checks++; if (hdr_ignore !== 1'b0) begin failures++; $display("[TB] FAIL entry_ignore: got %b expected 0", hdr_ignore); end
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("[TB] FAIL entry_oe_in_hdr: got %b expected 0", sda_oe); end
  endtask

  task automatic test_hdr_exit();
    logic m, e3, e4;
    int oe0;
    oe0 = oe_cycles;
    bus_start();
    bus_byte(8'hFC);
    bus_bit(1'b1);
    checks++; if (hdr_en !== 1'b1) begin failures++; $display("[TB] FAIL hdr_holds_on_start: got %b expected 1", hdr_en); end
    checks++; if (oe_cycles - oe0 !== 0) begin failures++; $display("[TB] FAIL hdr_no_ack: got %0d expected 0", oe_cycles - oe0); end
    pulse_exit();
    checks++; if (hdr_en !== 1'b0) begin failures++; $display("[TB] FAIL exit_hdr_en: got %b expected 0", hdr_en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL exit_busy: got %b expected 0", busy); end
    bus_start();
    bus_byte(8'hFC);
    ack_slot(m);
    bus_byte(enthdr_code(3'd0));
    last_bit(1'b0, e3, e4);
    checks++; if (hdr_en !== 1'b1) begin failures++; $display("[TB] FAIL reenter_hdr_en: got %b expected 1", hdr_en); end
    checks++; if (hdr_mode !== 3'd0) begin failures++; $display("[TB] FAIL reenter_mode: got %0d expected 0", hdr_mode); end
    pulse_exit();
    clks(2);
  endtask

  task automatic test_parity_err();
    logic m;
    int e0;
    e0 = err_cycles;
    bus_start();
    bus_byte(8'hFC);
    ack_slot(m);
    bus_byte(8'h20);
    bus_bit(1'b1);
    clks(4);
    checks++; if (err_cycles - e0 !== 1) begin failures++; $display("[TB] FAIL parity_err_pulse_cycles: got %0d expected 1", err_cycles - e0); end
    checks++; if (hdr_en !== 1'b0) begin failures++; $display("[TB] FAIL parity_hdr_en: got %b expected 0", hdr_en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL parity_busy: got %b expected 0", busy); end
  endtask

  task automatic test_nack_and_ignore();
    logic m;
    int oe0;
    oe0 = oe_cycles;
    bus_start();
    bus_byte(8'hA4);
    ack_slot(m);
    checks++; if (m !== 1'b0) begin failures++; $display("[TB] FAIL nack_slot_oe: got %b expected 0", m); end
    checks++; if (oe_cycles - oe0 !== 0) begin failures++; $display("[TB] FAIL nack_oe_cycles: got %0d expected 0", oe_cycles - oe0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL nack_busy: got %b expected 0", busy); end
    bus_start();
    bus_byte(8'hFC);
    ack_slot(m);
    bus_byte(8'h23);
    bus_bit(1'b0);
    checks++; if (hdr_ignore !== 1'b1) begin failures++; $display("[TB] FAIL ignore_level: got %b expected 1", hdr_ignore); end
    checks++; if (hdr_en !== 1'b0) begin failures++; $display("[TB] FAIL ignore_hdr_en: got %b expected 0", hdr_en); end
    checks++; if (hdr_mode !== 3'd3) begin failures++; $display("[TB] FAIL ignore_mode: got %0d expected 3", hdr_mode); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL ignore_busy: got %b expected 1", busy); end
    pulse_exit();
    checks++; if (hdr_ignore !== 1'b0) begin failures++; $display("[TB] FAIL ignore_exit: got %b expected 0", hdr_ignore); end
    clks(2);
  endtask

  task automatic test_repeated_start();
    logic m;
    int e0;
    bus_start();
    bus_byte(8'hFC);
    ack_slot(m);
    bus_bit(1'b0); bus_bit(1'b0); bus_bit(1'b1); bus_bit(1'b0);
    bus_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL sr_busy: got %b expected 1", busy); end
    bus_byte(8'hFC);
    ack_slot(m);
    checks++; if (m !== 1'b1) begin failures++; $display("[TB] FAIL sr_ack: got %b expected 1", m); end
    bus_byte(8'h20);
    bus_bit(1'b0);
    checks++; if (hdr_en !== 1'b1) begin failures++; $display("[TB] FAIL sr_hdr_en: got %b expected 1", hdr_en); end
    pulse_exit();
    clks(2);
    e0 = err_cycles;
    bus_start();
    bus_byte(8'hFC);
    ack_slot(m);
    bus_byte(8'h06);
    bus_bit(1'b1);
    clks(4);
    checks++; if (err_cycles - e0 !== 0) begin failures++; $display("[TB] FAIL other_ccc_err: got %0d expected 0", err_cycles - e0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL other_ccc_busy: got %b expected 0", busy); end
    checks++; if (hdr_en !== 1'b0 || hdr_ignore !== 1'b0) begin failures++; $display("[TB] FAIL other_ccc_hdr: got %b%b expected 00", hdr_en, hdr_ignore); end
  endtask

  task automatic test_reset_mid_ack();
    bus_start();
    bus_byte(8'hFC);
    ctrl_sda = 1'b1; clks(4);
    ctrl_scl = 1'b1; clks(4);
    checks++; if (sda_oe !== 1'b1) begin failures++; $display("[TB] FAIL rst_ack_pre: got %b expected 1", sda_oe); end
    rst = 1'b1; clks(1);
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("[TB] FAIL rst_ack_oe: got %b expected 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_ack_busy: got %b expected 0", busy); end
    checks++; if (hdr_en !== 1'b0 || hdr_ignore !== 1'b0 || ccc_err !== 1'b0 || hdr_mode !== 3'd0) begin
      failures++; $display("[TB] FAIL rst_ack_outputs: got %b%b%b%0d expected 0000", hdr_en, hdr_ignore, ccc_err, hdr_mode);
    end
    rst = 1'b0; clks(4);
    ctrl_scl = 1'b0; clks(4);
    bus_stop();
  endtask

  task automatic test_disable_and_stop();
    bus_start();
    bus_byte(8'hFC);
    ctrl_sda = 1'b1; clks(4);
    ctrl_scl = 1'b1; clks(4);
    tgt_en = 1'b0; clks(1);
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("[TB] FAIL disable_oe: got %b expected 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL disable_busy: got %b expected 0", busy); end
    tgt_en = 1'b1; clks(3);
    ctrl_scl = 1'b0; clks(4);
    bus_stop();
    bus_start();
    bus_bit(1'b1); bus_bit(1'b1); bus_bit(1'b1);
    bus_stop();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL stop_in_addr_busy: got %b expected 0", busy); end
    pulse_exit();
    clks(2);
    checks++; if (busy !== 1'b0 || hdr_en !== 1'b0) begin failures++; $display("[TB] FAIL exit_in_idle: got %b%b expected 00", busy, hdr_en); end
  endtask

  initial begin
    $display("[TB] starting enthdr_tgt_detector bench");
    test_reset();
    test_enthdr0_entry();
    test_hdr_exit();
    test_parity_err();
    test_nack_and_ignore();
    test_repeated_start();
    test_reset_mid_ack();
    test_disable_and_stop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
